// File: rtl/flag_stack_register.sv
// -----------------------------------------------------------------------------
// flag_stack_register
//
// Status-flag register with a hardware save/restore LIFO used for interrupt and
// call context switching. The live flags take per-bit masked writes from the
// ALU. The stack lets the control unit push the live flags on entry, pop them
// on return, or exchange live flags with the stack top, each in one cycle.
//
// Optional feature macro: FLAG_STACK_ERR_EN
//   defined     -> stack_err is a sticky flag. It is set by a push when the
//                  stack is full or by a pop when the stack is empty, and is
//                  cleared only by rst.
//   not defined -> stack_err is tied to 0 and no error logic is built.
//
// Parameters
//   NFLAGS : number of flags (default bit order: 0 zero, 1 negative,
//            2 overflow, 3 carry)
//   DEPTH  : number of stack entries (>= 1)
//   CW     : occupancy counter width, derived as $clog2(DEPTH+1)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   write_enable in   update live flags from flags_in
//   write_mask   in   per-bit write enable for the live flags
//   flags_in     in   new flag values from the ALU
//   push         in   save the live flags onto the stack
//   pop          in   restore the live flags from the stack top
//   flags        out  live flags (registered)
//   top          out  current stack top, 0 when the stack is empty
//   count        out  stack occupancy, 0..DEPTH
//   full         out  count == DEPTH (registered)
//   empty        out  count == 0 (registered)
//   stack_err    out  sticky illegal-operation flag
// -----------------------------------------------------------------------------
module flag_stack_register #(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic [NFLAGS-1:0] write_mask,
    input  logic [NFLAGS-1:0] flags_in,
    input  logic              push,
    input  logic              pop,
    output logic [NFLAGS-1:0] flags,
    output logic [NFLAGS-1:0] top,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              stack_err
);

    // Width of a stack index. It must be at least 1 bit so that DEPTH == 1
    // still yields a legal vector.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q,  full_d;
    logic              empty_q, empty_d;
    logic [NFLAGS-1:0] stack_q [DEPTH];

    logic [IW-1:0]     top_idx_s;
    logic [IW-1:0]     wr_idx_s;
    logic [NFLAGS-1:0] top_s;
    logic              push_op_s;
    logic              pop_op_s;
    logic              xchg_s;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic              stack_we_s;
    logic [IW-1:0]     stack_widx_s;

    // Classify the requested stack operation and derive the stack indices.
    always_comb begin
        top_idx_s = IW'(count_q - CW'(1));
        wr_idx_s  = IW'(count_q);
        // If the stack is empty, a simultaneous push and pop degrades to a
        // plain push.
        push_op_s = push & (~pop | empty_q);
        pop_op_s  = pop & ~push;
        xchg_s    = push & pop & ~empty_q;
        push_ok_s = push_op_s & ~full_q;
        pop_ok_s  = pop_op_s & ~empty_q;
        if (empty_q) begin
            top_s = {NFLAGS{1'b0}};
        end else begin
            top_s = stack_q[top_idx_s];
        end
    end

    // Compute the next live flags, occupancy, status bits and stack write port.
    always_comb begin
        flags_d      = flags_q;
        count_d      = count_q;
        stack_we_s   = 1'b0;
        stack_widx_s = wr_idx_s;
        for (int i = 0; i < NFLAGS; i++) begin
            if (write_enable & write_mask[i]) begin
                flags_d[i] = flags_in[i];
            end else begin
                flags_d[i] = flags_q[i];
            end
        end
        if (xchg_s) begin
            // Exchange: the live write is ignored and the top entry takes the
            // pre-update live value.
            flags_d      = top_s;
            stack_we_s   = 1'b1;
            stack_widx_s = top_idx_s;
        end else if (pop_ok_s) begin
            flags_d = top_s;
            count_d = count_q - CW'(1);
        end else if (push_ok_s) begin
            stack_we_s   = 1'b1;
            stack_widx_s = wr_idx_s;
            count_d      = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
    end

    // Live flags, occupancy and registered full/empty status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= {NFLAGS{1'b0}};
            count_q <= {CW{1'b0}};
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Stack storage. Its contents are not reset, and popped entries keep their
    // values.
    always_ff @(posedge clk) begin
        if (stack_we_s) begin
            stack_q[stack_widx_s] <= flags_q;
        end
    end

`ifdef FLAG_STACK_ERR_EN
    logic err_q, err_d;

    // The sticky error bit is set by an illegal push or pop.
    always_comb begin
        if ((push_op_s & full_q) | (pop_op_s & empty_q)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign stack_err = err_q;
`else
    assign stack_err = 1'b0;
`endif

    assign flags = flags_q;
    assign top   = top_s;
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_flag_stack_register.sv
// -----------------------------------------------------------------------------
// tb_flag_stack_register
//
// Directed, self-checking bench for flag_stack_register (NFLAGS=4, DEPTH=4).
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled at
// that same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_flag_stack_register;

    localparam int NFLAGS = 4;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

`ifdef FLAG_STACK_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              write_enable;
    logic [NFLAGS-1:0] write_mask;
    logic [NFLAGS-1:0] flags_in;
    logic              push;
    logic              pop;
    logic [NFLAGS-1:0] flags;
    logic [NFLAGS-1:0] top;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              stack_err;

    int total_q;
    int bad_q;

    flag_stack_register #(
        .NFLAGS(NFLAGS),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .write_enable(write_enable),
        .write_mask  (write_mask),
        .flags_in    (flags_in),
        .push        (push),
        .pop         (pop),
        .flags       (flags),
        .top         (top),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .stack_err   (stack_err)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_q++;
        if (got !== exp) begin
            bad_q++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of controls and clock it in.
    task automatic drive(input logic we, input logic [3:0] msk, input logic [3:0] din,
                         input logic ps, input logic pp);
        write_enable = we;
        write_mask   = msk;
        flags_in     = din;
        push         = ps;
        pop          = pp;
        tick();
    endtask

    // Check every output against expected values.
    task automatic check_all(input string tag, input logic [3:0] f, input logic [3:0] t,
                             input int c, input logic fu, input logic em, input logic er);
        check_val({tag, ".flags"}, 32'(flags), 32'(f));
        check_val({tag, ".top"},   32'(top),   32'(t));
        check_val({tag, ".count"}, 32'(count), 32'(c));
        check_val({tag, ".full"},  32'(full),  32'(fu));
        check_val({tag, ".empty"}, 32'(empty), 32'(em));
        check_val({tag, ".err"},   32'(stack_err), 32'(er));
    endtask

    initial begin
        total_q      = 0;
        bad_q        = 0;
        rst          = 1'b1;
        write_enable = 1'b0;
        write_mask   = 4'h0;
        flags_in     = 4'h0;
        push         = 1'b0;
        pop          = 1'b0;
        tick();
        tick();
        check_all("reset", 4'h0, 4'h0, 0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;

        // Masked live writes.
        drive(1'b1, 4'b1111, 4'b1010, 1'b0, 1'b0);
        check_all("wr_full", 4'b1010, 4'h0, 0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 4'b0001, 4'b0101, 1'b0, 1'b0);
        check_all("wr_mask", 4'b1011, 4'h0, 0, 1'b0, 1'b1, 1'b0);

        // A push with a same-cycle write, then a pop.
        drive(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
        check_all("push_wr", 4'b0000, 4'b1011, 1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1);
        check_all("pop1", 4'b1011, 4'h0, 0, 1'b0, 1'b1, 1'b0);

        // Fill the stack with 1,2,3,4.
        drive(1'b1, 4'b1111, 4'd1, 1'b0, 1'b0);
        drive(1'b1, 4'b1111, 4'd2, 1'b1, 1'b0);
        drive(1'b1, 4'b1111, 4'd3, 1'b1, 1'b0);
        drive(1'b1, 4'b1111, 4'd4, 1'b1, 1'b0);
        check_all("fill3", 4'd4, 4'd3, 3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 4'd0, 1'b1, 1'b0);
        check_all("fill4", 4'd4, 4'd4, 4, 1'b1, 1'b0, 1'b0);

        // A push when the stack is full: the live write still applies.
        drive(1'b1, 4'b0010, 4'b1111, 1'b1, 1'b0);
        check_all("push_full", 4'd6, 4'd4, 4, 1'b1, 1'b0, ERR_ON);

        // Pops restore 4,3,2,1.
        drive(1'b0, 4'b0000, 4'd0, 1'b0, 1'b1);
        check_all("pop_a", 4'd4, 4'd3, 3, 1'b0, 1'b0, ERR_ON);
        drive(1'b0, 4'b0000, 4'd0, 1'b0, 1'b1);
        check_all("pop_b", 4'd3, 4'd2, 2, 1'b0, 1'b0, ERR_ON);
        drive(1'b0, 4'b0000, 4'd0, 1'b0, 1'b1);
        check_all("pop_c", 4'd2, 4'd1, 1, 1'b0, 1'b0, ERR_ON);
        drive(1'b0, 4'b0000, 4'd0, 1'b0, 1'b1);
        check_all("pop_d", 4'd1, 4'd0, 0, 1'b0, 1'b1, ERR_ON);

        // A pop when the stack is empty: the live write applies.
        drive(1'b1, 4'b1111, 4'b0110, 1'b0, 1'b1);
        check_all("pop_empty", 4'b0110, 4'd0, 0, 1'b0, 1'b1, ERR_ON);

        // Exchange with count=2, flags=0011, top=1100.
        drive(1'b1, 4'b1111, 4'b1100, 1'b1, 1'b0);
        drive(1'b1, 4'b1111, 4'b0011, 1'b1, 1'b0);
        check_all("pre_xchg", 4'b0011, 4'b1100, 2, 1'b0, 1'b0, ERR_ON);
        drive(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1);
        check_all("xchg", 4'b1100, 4'b0011, 2, 1'b0, 1'b0, ERR_ON);

        // Reach count=3, then pulse reset asynchronously mid-cycle.
        drive(1'b0, 4'b0000, 4'd0, 1'b1, 1'b0);
        check_all("pre_rst", 4'b1100, 4'b1100, 3, 1'b0, 1'b0, ERR_ON);
        write_enable = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        rst          = 1'b1;
        #2;
        check_all("async_rst", 4'h0, 4'h0, 0, 1'b0, 1'b1, 1'b0);
        #4;
        rst = 1'b0;
        tick();
        check_all("post_rst", 4'h0, 4'h0, 0, 1'b0, 1'b1, 1'b0);

        // An exchange when the stack is empty acts as a push, and the live write applies.
        drive(1'b1, 4'b1111, 4'b0101, 1'b0, 1'b0);
        drive(1'b1, 4'b1111, 4'b1001, 1'b1, 1'b1);
        check_all("xchg_empty", 4'b1001, 4'b0101, 1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total_q, bad_q);
        $finish;
    end

endmodule
